// File: rtl/mmu_pkg.sv
// mmu_pkg: shared Sv39 constants, PTE bit positions and page-table-walker state encoding.
package mmu_pkg;
  localparam logic [3:0] SATP_MODE_BARE = 4'h0;
  localparam logic [3:0] SATP_MODE_SV39 = 4'h8;
  localparam logic [1:0] ACC_FETCH = 2'b00;
  localparam logic [1:0] ACC_LOAD  = 2'b01;
  localparam logic [1:0] ACC_STORE = 2'b10;
  localparam logic [1:0] ACC_RSVD  = 2'b11;
  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} ptw_state_e;
endpackage

// File: rtl/mmu_pte_check.sv
// mmu_pte_check: combinational Sv39 PTE evaluation (leaf detect, permission/alignment fault, leaf paddr).
// Define MMU_PTW_AD_CHECK_EN to fault leaves with A=0, or stores to leaves with D=0.
module mmu_pte_check
  import mmu_pkg::*;
(
  input  logic [63:0] pte_i,
  input  logic [1:0]  level_i,
  input  logic [1:0]  acc_i,
  input  logic [29:0] va_i,
  output logic        is_leaf_o,
  output logic        fault_o,
  output logic [55:0] paddr_o
);
  logic [43:0] ppn;
  logic v, r, w, x, perm_ok, misal, ad_fault;
  logic unused_pte;
  assign unused_pte = ^{pte_i[63:54], pte_i[9:8], pte_i[PTE_U], pte_i[PTE_G], pte_i[PTE_A], pte_i[PTE_D]};
  assign ppn = pte_i[PTE_PPN_MSB:PTE_PPN_LSB];
  assign v = pte_i[PTE_V];
  assign r = pte_i[PTE_R];
  assign w = pte_i[PTE_W];
  assign x = pte_i[PTE_X];
  assign is_leaf_o = r | x;
  assign perm_ok = acc_i == ACC_FETCH ? x : acc_i == ACC_STORE ? (r & w) : r;
  assign misal = level_i == 2'd2 ? |ppn[17:0] : level_i == 2'd1 ? |ppn[8:0] : 1'b0;
`ifdef MMU_PTW_AD_CHECK_EN
  assign ad_fault = !pte_i[PTE_A] | (acc_i == ACC_STORE && !pte_i[PTE_D]);
`else
  assign ad_fault = 1'b0;
`endif
  // A pointer at level 0 has nowhere left to go.
  assign fault_o = !v | (!r & w) | (is_leaf_o ? (!perm_ok | misal | ad_fault) : level_i == 2'd0);
  assign paddr_o = level_i == 2'd2 ? {ppn[43:18], va_i[29:0]} :
                   level_i == 2'd1 ? {ppn[43:9], va_i[20:0]} : {ppn, va_i[11:0]};
endmodule

// File: rtl/mmu_ptw.sv
// mmu_ptw: Sv39 page-table walker with a single-outstanding PTE read port.
// Define MMU_PTW_AD_CHECK_EN to enable accessed/dirty-bit faulting in mmu_pte_check.
module mmu_ptw
  import mmu_pkg::*;
#(
  parameter int PTE_BASE_W = 56
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ptw_i_req_valid,
  output logic        ptw_o_req_ready,
  input  logic [63:0] ptw_i_vaddr,
  input  logic [63:0] ptw_i_satp,
  input  logic [1:0]  ptw_i_acc_type,
  output logic        ptw_o_mem_valid,
  input  logic        ptw_i_mem_ready,
  output logic [63:0] ptw_o_mem_addr,
  input  logic        ptw_i_mem_rvalid,
  input  logic [63:0] ptw_i_mem_rdata,
  output logic        ptw_o_resp_valid,
  input  logic        ptw_i_resp_ready,
  output logic [63:0] ptw_o_paddr,
  output logic        ptw_o_fault
);
  ptw_state_e state_q, state_d;
  logic [38:0] va_q, va_d;
  logic [1:0]  acc_q, acc_d, level_q, level_d;
  logic [43:0] base_q, base_d;
  logic [63:0] paddr_q, paddr_d;
  logic        fault_q, fault_d;
  logic [8:0]  vpn;
  logic [PTE_BASE_W-1:0] pte_addr;
  logic        chk_leaf, chk_fault, canonical;
  logic [55:0] chk_paddr;
  logic        unused_satp;
  assign unused_satp = ^ptw_i_satp[59:44];
  mmu_pte_check u_chk (
    .pte_i     (ptw_i_mem_rdata),
    .level_i   (level_q),
    .acc_i     (acc_q),
    .va_i      (va_q[29:0]),
    .is_leaf_o (chk_leaf),
    .fault_o   (chk_fault),
    .paddr_o   (chk_paddr)
  );
  assign vpn = level_q == 2'd2 ? va_q[38:30] : level_q == 2'd1 ? va_q[29:21] : va_q[20:12];
  assign pte_addr = {base_q, vpn, 3'b000};
  assign canonical = ptw_i_vaddr[63:39] == {25{ptw_i_vaddr[38]}};
  assign ptw_o_req_ready = state_q == ST_IDLE;
  assign ptw_o_mem_valid = state_q == ST_REQ;
  assign ptw_o_mem_addr = state_q == ST_REQ ? 64'(pte_addr) : 64'd0;
  assign ptw_o_resp_valid = state_q == ST_DONE;
  assign ptw_o_paddr = paddr_q;
  assign ptw_o_fault = fault_q;
  always_comb begin
    state_d = state_q;
    va_d = va_q;
    acc_d = acc_q;
    level_d = level_q;
    base_d = base_q;
    paddr_d = paddr_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: if (ptw_i_req_valid) begin
        va_d = ptw_i_vaddr[38:0];
        acc_d = ptw_i_acc_type == ACC_RSVD ? ACC_LOAD : ptw_i_acc_type;
        level_d = 2'd2;
        base_d = ptw_i_satp[43:0];
        paddr_d = ptw_i_satp[63:60] == SATP_MODE_BARE ? ptw_i_vaddr : 64'd0;
        fault_d = !(ptw_i_satp[63:60] == SATP_MODE_BARE || (ptw_i_satp[63:60] == SATP_MODE_SV39 && canonical));
        state_d = ptw_i_satp[63:60] == SATP_MODE_SV39 && canonical ? ST_REQ : ST_DONE;
      end
      ST_REQ: state_d = ptw_i_mem_ready ? ST_WAIT : ST_REQ;
      ST_WAIT: if (ptw_i_mem_rvalid) begin
        fault_d = chk_fault;
        paddr_d = chk_fault ? 64'd0 : 64'(chk_paddr);
        base_d = ptw_i_mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];
        level_d = chk_fault | chk_leaf ? level_q : level_q - 2'd1;
        state_d = chk_fault | chk_leaf ? ST_DONE : ST_REQ;
      end
      ST_DONE: state_d = ptw_i_resp_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      va_q <= '0;
      acc_q <= '0;
      level_q <= '0;
      base_q <= '0;
      paddr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      va_q <= va_d;
      acc_q <= acc_d;
      level_q <= level_d;
      base_q <= base_d;
      paddr_q <= paddr_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_mmu_ptw.sv
// tb_mmu_ptw: directed-vector bench for the Sv39 walker with a scripted single-outstanding memory.
module tb_mmu_ptw;
  logic        clock = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, mem_ready = 1'b0, mem_rvalid = 1'b0, resp_ready = 1'b0;
  logic [63:0] vaddr = '0, satp = '0, mem_rdata = '0;
  logic [1:0]  acc_type = '0;
  logic        req_ready, mem_valid, resp_valid, fault;
  logic [63:0] mem_addr, paddr;
  int n_chk = 0, n_err = 0, cyc = 0, t_acc = 0;
`ifdef MMU_PTW_AD_CHECK_EN
  localparam logic AD = 1'b1;
`else
  localparam logic AD = 1'b0;
`endif
  localparam logic [63:0] SATP_SV39 = 64'h8000_0000_0008_0000;
  mmu_ptw dut (
    .clock(clock), .reset(reset),
    .ptw_i_req_valid(req_valid), .ptw_o_req_ready(req_ready),
    .ptw_i_vaddr(vaddr), .ptw_i_satp(satp), .ptw_i_acc_type(acc_type),
    .ptw_o_mem_valid(mem_valid), .ptw_i_mem_ready(mem_ready), .ptw_o_mem_addr(mem_addr),
    .ptw_i_mem_rvalid(mem_rvalid), .ptw_i_mem_rdata(mem_rdata),
    .ptw_o_resp_valid(resp_valid), .ptw_i_resp_ready(resp_ready),
    .ptw_o_paddr(paddr), .ptw_o_fault(fault)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic req(input string tag, input logic [63:0] va, input logic [63:0] sa, input logic [1:0] acc);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; vaddr = va; satp = sa; acc_type = acc;
    tick;
    t_acc = cyc;
    req_valid = 1'b0; vaddr = 64'hdead_beef_dead_beef; satp = '0; acc_type = 2'b00;
  endtask
  task automatic serve(input string tag, input logic [63:0] addr, input logic [63:0] pte, input int stall);
    int k = 0;
    while (!mem_valid && k < 20) begin tick; k++; end
    check({tag, "_mem_valid"}, 64'(mem_valid), 64'd1);
    check({tag, "_mem_addr"}, mem_addr, addr);
    for (int i = 0; i < stall; i++) begin
      tick;
      check({tag, "_hold_valid"}, 64'(mem_valid), 64'd1);
      check({tag, "_hold_addr"}, mem_addr, addr);
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = pte;
    tick;
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask
  task automatic respond(input string tag, input logic [63:0] pa, input logic flt, input int lat, input int hold);
    int k = 0;
    while (!resp_valid && k < 20) begin tick; k++; end
    check({tag, "_lat"}, 64'(cyc - t_acc + 1), 64'(lat));
    check({tag, "_paddr"}, paddr, pa);
    check({tag, "_fault"}, 64'(fault), 64'(flt));
    for (int i = 0; i < hold; i++) begin
      tick;
      check({tag, "_hold_resp"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_paddr"}, paddr, pa);
      check({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    check({tag, "_b2b_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_resp_drop"}, 64'(resp_valid), 64'd0);
  endtask
  initial begin
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_outs", {60'd0, mem_valid, resp_valid, fault, 1'b0}, 64'd0);
    check("rst_addr", mem_addr | paddr, 64'd0);
    tick;
    reset = 1'b0;
    tick;
    req("bare", 64'h8000_1234, 64'd0, 2'b01);
    check("bare_no_mem", 64'(mem_valid), 64'd0);
    respond("bare", 64'h8000_1234, 1'b0, 1, 0);
    req("l2", 64'h4000_0000, SATP_SV39, 2'b01);
    serve("l2", 64'h8000_0008, 64'h2000_00CF, 0);
    respond("l2", 64'h8000_0000, 1'b0, 3, 0);
    req("l0", 64'h0060_5123, SATP_SV39, 2'b01);
    serve("l0_a", 64'h8000_0000, 64'h2000_0401, 0);
    serve("l0_b", 64'h8000_1018, 64'h2000_0801, 0);
    serve("l0_c", 64'h8000_2028, 64'h2000_0C4B, 0);
    respond("l0", 64'h8000_3123, 1'b0, 7, 0);
    req("l0st", 64'h0060_5123, SATP_SV39, 2'b10);
    serve("l0st_a", 64'h8000_0000, 64'h2000_0401, 0);
    serve("l0st_b", 64'h8000_1018, 64'h2000_0801, 0);
    serve("l0st_c", 64'h8000_2028, 64'h2000_0C4B, 0);
    respond("l0st", 64'd0, 1'b1, 7, 0);
    req("inv", 64'h4000_0000, SATP_SV39, 2'b00);
    serve("inv", 64'h8000_0008, 64'd0, 0);
    respond("inv", 64'd0, 1'b1, 3, 0);
    req("misal", 64'h4000_0000, SATP_SV39, 2'b01);
    serve("misal_a", 64'h8000_0008, 64'h2000_0401, 0);
    serve("misal_b", 64'h8000_1000, 64'h2000_04CF, 0);
    respond("misal", 64'd0, 1'b1, 5, 0);
    req("noncanon", 64'h0000_0080_0000_0000, SATP_SV39, 2'b01);
    check("noncanon_no_mem", 64'(mem_valid), 64'd0);
    respond("noncanon", 64'd0, 1'b1, 1, 0);
    req("mode9", 64'h4000_0000, 64'h9000_0000_0008_0000, 2'b01);
    check("mode9_no_mem", 64'(mem_valid), 64'd0);
    respond("mode9", 64'd0, 1'b1, 1, 0);
    req("rsvd_acc", 64'h4000_0000, SATP_SV39, 2'b11);
    serve("rsvd_acc", 64'h8000_0008, 64'h2000_00C9, 0);
    respond("rsvd_acc", 64'd0, 1'b1, 3, 0);
    req("stall", 64'h4000_0000, SATP_SV39, 2'b10);
    serve("stall", 64'h8000_0008, 64'h2000_00CF, 4);
    respond("stall", 64'h8000_0000, 1'b0, 7, 3);
    req("a_clr", 64'h4000_0000, SATP_SV39, 2'b01);
    serve("a_clr", 64'h8000_0008, 64'h2000_008F, 0);
    respond("a_clr", AD ? 64'd0 : 64'h8000_0000, AD, 3, 0);
    req("d_clr", 64'h4000_0000, SATP_SV39, 2'b10);
    serve("d_clr", 64'h8000_0008, 64'h2000_004F, 0);
    respond("d_clr", AD ? 64'd0 : 64'h8000_0000, AD, 3, 0);
    req("rst_wait", 64'h4000_0000, SATP_SV39, 2'b01);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("rstw_req_ready", 64'(req_ready), 64'd1);
    check("rstw_outs", {61'd0, mem_valid, resp_valid, fault}, 64'd0);
    check("rstw_addr", mem_addr | paddr, 64'd0);
    tick;
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h2000_00CF;
    tick;
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick;
    check("late_rvalid_resp", 64'(resp_valid), 64'd0);
    check("late_rvalid_ready", 64'(req_ready), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
